// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: instruction opcodes, ALU op codes,
// branch condition codes, FSM state constants and the decode bundle.
package alu_pkg;

    localparam logic [3:0] OPC_ADD = 4'd0;
    localparam logic [3:0] OPC_SUB = 4'd1;
    localparam logic [3:0] OPC_AND = 4'd2;
    localparam logic [3:0] OPC_OR  = 4'd3;
    localparam logic [3:0] OPC_BR  = 4'd4;
    localparam logic [3:0] OPC_PAR = 4'd5;

    localparam logic [3:0] ALU_OP_ADDSUB = 4'd0;
    localparam logic [3:0] ALU_OP_AND    = 4'd2;
    localparam logic [3:0] ALU_OP_OR     = 4'd3;
    localparam logic [3:0] ALU_OP_CMP    = 4'd4;
    localparam logic [3:0] ALU_OP_PAR    = 4'd5;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_LE = 4'd1;
    localparam logic [3:0] COND_GE = 4'd2;
    localparam logic [3:0] COND_NE = 4'd3;
    localparam logic [3:0] COND_LT = 4'd4;
    localparam logic [3:0] COND_GT = 4'd5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_WB   = 2'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_eq;
        logic [2:0] alu_ltgt;
        logic       is_branch;
        logic       is_illegal;
        logic       never_taken;
    } decode_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: opcode/cond fields to ALU controls and
// instruction class flags.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [3:0] cond_i,
    output decode_t    dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.alu_eq = 1'b1;
        case (opcode_i)
            OPC_ADD: dec_o.alu_op = ALU_OP_ADDSUB;
            OPC_SUB: begin
                dec_o.alu_op = ALU_OP_ADDSUB;
                dec_o.alu_eq = 1'b0;
            end
            OPC_AND: dec_o.alu_op = ALU_OP_AND;
            OPC_OR:  dec_o.alu_op = ALU_OP_OR;
            OPC_PAR: dec_o.alu_op = ALU_OP_PAR;
            OPC_BR: begin
                dec_o.alu_op    = ALU_OP_CMP;
                dec_o.is_branch = 1'b1;
                // Negated conditions reuse the positive selector with eq cleared.
                case (cond_i)
                    COND_EQ, COND_LE, COND_GE: dec_o.alu_ltgt = cond_i[2:0];
                    COND_NE, COND_LT, COND_GT: begin
                        dec_o.alu_eq   = 1'b0;
                        dec_o.alu_ltgt = cond_i[2:0] - 3'd3;
                    end
                    default: dec_o.never_taken = 1'b1;
                endcase
            end
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue controller (IDLE/READ/EXEC/WB) driving the ALU operand and
// control inputs, then writing back to the register file or advancing the PC.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, and instr_valid
    // and instr are ignored in every other state.
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [RA_W-1:0]   rf_raddr_a,
    output logic [RA_W-1:0]   rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [3:0]        alu_op,
    output logic              alu_eq,
    output logic [2:0]        alu_ltgt,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] alu_register,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_compres,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              branch_taken,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [15:0]       instr_q;
    logic [3:0]        alu_op_q;
    logic              alu_eq_q;
    logic [2:0]        alu_ltgt_q;
    logic [DATA_W-1:0] alu_res_q, alu_reg_q;
    logic              rf_we_q, branch_q, illegal_q;
    logic [RA_W-1:0]   rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken;
    decode_t           dec;

    alu_issue_decode u_decode (
        .opcode_i (instr_q[15:12]),
        .cond_i   (instr_q[3:0]),
        .dec_o    (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare flag is only meaningful for a branch with a real condition.
    assign taken = dec.is_branch && !dec.never_taken && alu_compres;

    always_comb begin
        pc_d = pc_q;
        if (state_q == ST_EXEC) begin
            pc_d = taken ? pc_q + PC_W'(2) : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alu_op_q   <= '0;
            alu_eq_q   <= 1'b1;
            alu_ltgt_q <= '0;
            alu_res_q  <= '0;
            alu_reg_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rf_we_q   <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                ST_READ: begin
                    // Illegal opcodes leave the ALU inputs untouched.
                    if (!dec.is_illegal) begin
                        alu_res_q  <= rf_rdata_a;
                        alu_reg_q  <= rf_rdata_b;
                        alu_op_q   <= dec.alu_op;
                        alu_eq_q   <= dec.alu_eq;
                        alu_ltgt_q <= dec.alu_ltgt;
                    end
                end
                ST_EXEC: begin
                    if (!dec.is_branch && !dec.is_illegal) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= RA_W'(instr_q[11:8]);
                        rf_wdata_q <= alu_out;
                    end
                    branch_q  <= taken;
                    illegal_q <= dec.is_illegal;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready  = (state_q == ST_IDLE);
    assign rf_raddr_a   = RA_W'(instr_q[11:8]);
    assign rf_raddr_b   = RA_W'(instr_q[7:4]);
    assign alu_op       = alu_op_q;
    assign alu_eq       = alu_eq_q;
    assign alu_ltgt     = alu_ltgt_q;
    assign alu_res      = alu_res_q;
    assign alu_register = alu_reg_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU models around the controller,
// directed instructions with hand-computed outcomes, scoreboard-checked writeback.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [15:0] rf_rdata_a, rf_rdata_b;
    logic [3:0]  alu_op;
    logic        alu_eq;
    logic [2:0]  alu_ltgt;
    logic [15:0] alu_res, alu_register;
    logic [15:0] alu_out;
    logic        alu_compres;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  pc;
    logic        branch_taken;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    // Item: {mask[8], busy[4], pulse_idx[4], flags{ill,br,we}[3], pulse_cnt[2], waddr[4], wdata[16], pc[8], exec[8]}
    logic [56:0] exp_q[$];

    alu_issue_ctrl #(.PC_W(8), .DATA_W(16), .RA_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_raddr_a   (rf_raddr_a),
        .rf_raddr_b   (rf_raddr_b),
        .rf_rdata_a   (rf_rdata_a),
        .rf_rdata_b   (rf_rdata_b),
        .alu_op       (alu_op),
        .alu_eq       (alu_eq),
        .alu_ltgt     (alu_ltgt),
        .alu_res      (alu_res),
        .alu_register (alu_register),
        .alu_out      (alu_out),
        .alu_compres  (alu_compres),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pc           (pc),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- register file and ALU models ----------------
    logic [15:0] rf_m [16];
    logic        rf_clr;
    logic        poke_en;
    logic [3:0]  poke_addr;
    logic [15:0] poke_data;

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf_m[i] <= 16'h0;
        end else if (poke_en) begin
            rf_m[poke_addr] <= poke_data;
        end else if (rf_we) begin
            rf_m[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata_a = rf_m[rf_raddr_a];
    assign rf_rdata_b = rf_m[rf_raddr_b];

    always_comb begin
        alu_out     = 16'h0;
        alu_compres = 1'b0;
        case (alu_op)
            4'd0: alu_out = alu_eq ? alu_res + alu_register : alu_res - alu_register;
            4'd2: alu_out = alu_res & alu_register;
            4'd3: alu_out = alu_res | alu_register;
            4'd5: alu_out = {15'h0, ^alu_res};
            4'd4: begin
                case ({alu_eq, alu_ltgt})
                    4'b1000: alu_compres = (alu_res == alu_register);
                    4'b1001: alu_compres = (alu_res <= alu_register);
                    4'b1010: alu_compres = (alu_res >= alu_register);
                    4'b0000: alu_compres = (alu_res != alu_register);
                    4'b0001: alu_compres = (alu_res <  alu_register);
                    4'b0010: alu_compres = (alu_res >  alu_register);
                    default: alu_compres = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // ---------------- expected-item helpers ----------------
    function automatic logic [56:0] mk(input logic [3:0] busy, input logic [2:0] flags,
                                       input logic [3:0] wa, input logic [15:0] wd,
                                       input logic [7:0] pcv, input logic [7:0] mask,
                                       input logic [7:0] ex);
        logic [3:0] pidx;
        logic [1:0] pcnt;
        pidx = (flags != 3'b000) ? 4'd2 : 4'd0;
        pcnt = (flags != 3'b000) ? 2'd1 : 2'd0;
        return {mask, busy, pidx, flags, pcnt, wa, wd, pcv, ex & mask};
    endfunction

    function automatic logic [7:0] ex(input logic [3:0] op, input logic eq, input logic [2:0] lt);
        return {op, eq, lt};
    endfunction

    function automatic logic [56:0] e_wr(input logic [3:0] wa, input logic [15:0] wd,
                                         input logic [7:0] pcv, input logic [7:0] mask,
                                         input logic [7:0] x);
        return mk(4'd3, 3'b001, wa, wd, pcv, mask, x);
    endfunction

    function automatic logic [56:0] e_br(input logic tk, input logic [7:0] pcv,
                                         input logic [7:0] mask, input logic [7:0] x);
        return mk(4'd3, tk ? 3'b010 : 3'b000, 4'd0, 16'h0, pcv, mask, x);
    endfunction

    function automatic logic [56:0] e_ill(input logic [7:0] pcv, input logic [7:0] x);
        return mk(4'd3, 3'b100, 4'd0, 16'h0, pcv, 8'hFF, x);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clock);
        #1 poke_en = 1'b0;
    endtask

    // Holds instr_valid through the busy period with scrambled instr to show both are ignored.
    task automatic issue(input logic [15:0] ins, input logic [56:0] e);
        int n;
        exp_q.push_back(e);
        @(negedge clock);
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", 64'(n < 20), 64'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr = 16'($urandom_range(0, 65535));
        n = 0;
        @(negedge clock);
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            instr = 16'($urandom_range(0, 65535));
            n++;
        end
        instr_valid = 1'b0;
        check("done_wait", 64'(n < 20), 64'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [3:0]  m_busy  = 4'd0;
    logic [3:0]  m_pidx  = 4'd0;
    logic [2:0]  m_flags = 3'b000;
    logic [1:0]  m_pcnt  = 2'd0;
    logic [3:0]  m_wa    = 4'd0;
    logic [15:0] m_wd    = 16'h0;
    logic [7:0]  m_exec  = 8'h0;
    int          stray   = 0;

    always @(negedge clock) begin
        logic [56:0] e;
        logic [48:0] act;
        if (!instr_ready) begin
            if (m_busy == 4'd1) m_exec = {alu_op, alu_eq, alu_ltgt};
            if (rf_we || branch_taken || illegal) begin
                m_flags = m_flags | {illegal, branch_taken, rf_we};
                if (m_pcnt != 2'd3) m_pcnt = m_pcnt + 2'd1;
                m_pidx = m_busy;
                if (rf_we) begin
                    m_wa = rf_waddr;
                    m_wd = rf_wdata;
                end
            end
            m_busy = m_busy + 4'd1;
        end else begin
            if (rf_we || branch_taken || illegal) stray++;
            if (m_busy != 4'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_event act=unexpected_completion pc=%0h req=none", pc);
                end else begin
                    e   = exp_q.pop_front();
                    act = {m_busy, m_pidx, m_flags, m_pcnt, m_wa, m_wd, pc, m_exec & e[56:49]};
                    if (act !== e[48:0]) begin
                        errors++;
                        $display("FAIL wb_event act=%h req=%h (busy,idx,flags,cnt,wa,wd,pc,exec)",
                                 act, e[48:0]);
                    end
                end
                m_busy  = 4'd0;
                m_pidx  = 4'd0;
                m_flags = 3'b000;
                m_pcnt  = 2'd0;
                m_wa    = 4'd0;
                m_wd    = 16'h0;
                m_exec  = 8'h0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n     = 1'b0;
        rf_clr      = 1'b1;
        poke_en     = 1'b0;
        poke_addr   = 4'd0;
        poke_data   = 16'h0;
        instr_valid = 1'b0;
        instr       = 16'h0;
        repeat (2) @(negedge clock);

        check("rst_ready",  instr_ready, 64'd1);
        check("rst_pc",     pc, 64'd0);
        check("rst_pulses", {rf_we, branch_taken, illegal}, 64'd0);
        check("rst_alu_ctl", {alu_op, alu_eq, alu_ltgt}, 64'h08);
        check("rst_alu_opnd", {alu_res, alu_register}, 64'd0);
        check("rst_wb_addr", {rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b}, 64'd0);

        rf_clr  = 1'b0;
        reset_n = 1'b1;

        set_reg(4'd1, 16'd7);
        set_reg(4'd2, 16'd5);
        issue(16'h0120, e_wr(4'd1, 16'h000C, 8'h01, 8'hFF, ex(4'd0, 1'b1, 3'd0)));
        set_reg(4'd1, 16'd7);
        issue(16'h1120, e_wr(4'd1, 16'h0002, 8'h02, 8'hFF, ex(4'd0, 1'b0, 3'd0)));
        set_reg(4'd3, 16'h0003);
        issue(16'h5300, e_wr(4'd3, 16'h0000, 8'h03, 8'hF0, ex(4'd5, 1'b0, 3'd0)));
        set_reg(4'd3, 16'h0007);
        issue(16'h5300, e_wr(4'd3, 16'h0001, 8'h04, 8'hF0, ex(4'd5, 1'b0, 3'd0)));

        set_reg(4'd4, 16'd9);
        set_reg(4'd5, 16'd9);
        issue(16'h4450, e_br(1'b1, 8'h06, 8'hFF, ex(4'd4, 1'b1, 3'd0)));
        set_reg(4'd5, 16'd10);
        issue(16'h4455, e_br(1'b0, 8'h07, 8'hFF, ex(4'd4, 1'b0, 3'd2)));
        issue(16'hF000, e_ill(8'h08, ex(4'd4, 1'b0, 3'd2)));

        set_reg(4'd6, 16'h00F0);
        set_reg(4'd7, 16'h0FFF);
        issue(16'h2670, e_wr(4'd6, 16'h00F0, 8'h09, 8'hF0, ex(4'd2, 1'b0, 3'd0)));
        set_reg(4'd8, 16'h1200);
        set_reg(4'd9, 16'h0034);
        issue(16'h3890, e_wr(4'd8, 16'h1234, 8'h0A, 8'hF0, ex(4'd3, 1'b0, 3'd0)));

        set_reg(4'd5, 16'd9);
        issue(16'h4456, e_br(1'b0, 8'h0B, 8'hF0, ex(4'd4, 1'b0, 3'd0)));
        issue(16'h4458, e_br(1'b0, 8'h0C, 8'hF0, ex(4'd4, 1'b0, 3'd0)));
        set_reg(4'd4, 16'd3);
        issue(16'h4454, e_br(1'b1, 8'h0E, 8'hFF, ex(4'd4, 1'b0, 3'd1)));
        issue(16'h4452, e_br(1'b0, 8'h0F, 8'hFF, ex(4'd4, 1'b1, 3'd2)));
        set_reg(4'd4, 16'd9);
        issue(16'h4451, e_br(1'b1, 8'h11, 8'hFF, ex(4'd4, 1'b1, 3'd1)));
        issue(16'h4453, e_br(1'b0, 8'h12, 8'hFF, ex(4'd4, 1'b0, 3'd0)));
        issue(16'h6000, e_ill(8'h13, ex(4'd4, 1'b0, 3'd0)));

        // Walk the PC up to 0xFF through every illegal opcode; ALU controls must stay put.
        for (int p = 'h13; p < 'hFF; p++) begin
            logic [3:0] oc;
            oc = 4'(6 + (p % 10));
            issue({oc, 12'h000}, e_ill(8'(p + 1), ex(4'd4, 1'b0, 3'd0)));
        end
        issue(16'h4450, e_br(1'b1, 8'h01, 8'hFF, ex(4'd4, 1'b1, 3'd0)));
        issue(16'h0000, e_wr(4'd0, 16'h0000, 8'h02, 8'hFF, ex(4'd0, 1'b1, 3'd0)));

        // Reset while the instruction is in EXEC: no write, PC and ready recover at once.
        set_reg(4'd1, 16'd7);
        set_reg(4'd2, 16'd5);
        exp_q.push_back(mk(4'd1, 3'b000, 4'd0, 16'h0, 8'h00, 8'h00, 8'h00));
        @(negedge clock);
        instr       = 16'h0120;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ready", instr_ready, 64'd1);
        check("midrst_pc",    pc, 64'd0);
        check("midrst_we",    rf_we, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_no_write", rf_m[1], 64'd7);

        issue(16'h0120, e_wr(4'd1, 16'h000C, 8'h01, 8'hFF, ex(4'd0, 1'b1, 3'd0)));

        repeat (5) @(negedge clock);
        check("queue_empty",  exp_q.size(), 64'd0);
        check("stray_pulses", stray, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
